// File: rtl/store_seq_pkg.sv
// store_seq_pkg: shared definitions for the store sequencer.
//   state_t    : sequencer state encoding (IDLE / WRITE)
//   wr_t       : store size codes carried on wr0/wr1
//   byte_count : number of RAM bytes written for a given size code
package store_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_B1   = 2'b01,
        WR_B4   = 2'b10,
        WR_B8   = 2'b11
    } wr_t;

    function automatic logic [3:0] byte_count(input wr_t wr);
        case (wr)
            WR_B1:   return 4'd1;
            WR_B4:   return 4'd4;
            WR_B8:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_seq_arb.sv
// store_seq_arb: 2-way request arbiter producing a one-hot grant.
// Macro STORE_SEQ_RR_EN: when defined, round-robin arbitration with an
// internal priority pointer (requester 0 favoured after reset); when
// undefined, fixed priority with requester 0 always winning and no state.
// Ports:
//   clk, rst_n    : clock / sync active-low reset (round-robin build only)
//   req0, req1    : requests
//   enable        : arbitration allowed this cycle
//   grant[1:0]    : one-hot grant, bit i = requester i; zero when disabled
module store_seq_arb
    import store_seq_pkg::*;
(
`ifdef STORE_SEQ_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       req0,
    input  logic       req1,
    input  logic       enable,
    output logic [1:0] grant
);

`ifdef STORE_SEQ_RR_EN
    // prio1 set: requester 1 wins the next conflict
    logic prio1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio1 <= 1'b0;
        end else if (enable && (req0 || req1)) begin
            // hand priority to whoever did not just win
            prio1 <= grant[0];
        end
    end

    always_comb begin
        grant = '0;
        if (enable) begin
            if (req0 && req1) begin
                grant = prio1 ? 2'b10 : 2'b01;
            end else begin
                grant = {req1, req0};
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        if (enable) begin
            if (req0) begin
                grant = 2'b01;
            end else if (req1) begin
                grant = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/store_sequencer.sv
// store_sequencer: serialises 1/4/8-byte stores from two requesters onto an
// 8-bit RAM write port, one byte per cycle, little-endian, addresses 16-bit
// modulo. Macro STORE_SEQ_RR_EN selects round-robin (defined) or fixed
// requester-0 priority (undefined) arbitration.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   req0/wr0/addr0/d0          : store request, size, start address, data (CPU)
//   req1/wr1/addr1/d1          : same for loader/debug requester
//   gnt0, gnt1                 : one-cycle capture pulse, aligned with byte 0
//   ram_we, ram_addr, ram_q    : registered byte write port
//   busy                       : high during every byte-write cycle
module store_sequencer
    import store_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [1:0]  wr0,
    input  logic [15:0] addr0,
    input  logic [63:0] d0,
    input  logic        req1,
    input  logic [1:0]  wr1,
    input  logic [15:0] addr1,
    input  logic [63:0] d1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_q,
    output logic        busy
);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;          // index of byte currently on the port
    logic [2:0]  last_idx, last_nxt;    // index of final byte of this store
    logic [63:0] data, data_nxt;
    logic        ram_we_nxt, gnt0_nxt, gnt1_nxt;
    logic [15:0] ram_addr_nxt;
    logic [7:0]  ram_q_nxt;

    logic        accept;
    logic [1:0]  grant;
    wr_t         wr_sel;
    logic [15:0] addr_sel;
    logic [63:0] d_sel;
    logic [2:0]  cnt_inc;

    // The edge that ends the last byte also samples requests, so a new store
    // can start without an idle cycle in between.
    assign accept  = (state == ST_IDLE) || (cnt == last_idx);
    assign cnt_inc = cnt + 3'd1;
    assign busy    = (state == ST_WRITE);

    store_seq_arb u_arb (
`ifdef STORE_SEQ_RR_EN
        .clk    (clk),
        .rst_n  (rst_n),
`endif
        .req0   (req0),
        .req1   (req1),
        .enable (accept),
        .grant  (grant)
    );

    always_comb begin
        wr_sel   = grant[1] ? wr_t'(wr1) : wr_t'(wr0);
        addr_sel = grant[1] ? addr1 : addr0;
        d_sel    = grant[1] ? d1 : d0;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_nxt     = last_idx;
        data_nxt     = data;
        ram_we_nxt   = 1'b0;
        ram_addr_nxt = ram_addr;
        ram_q_nxt    = ram_q;
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;

        if (!accept) begin
            cnt_nxt      = cnt_inc;
            ram_we_nxt   = 1'b1;
            ram_addr_nxt = ram_addr + 16'd1;
            ram_q_nxt    = data[{cnt_inc, 3'b000} +: 8];
        end else begin
            state_nxt = ST_IDLE;
            if (grant != 2'b00) begin
                gnt0_nxt = grant[0];
                gnt1_nxt = grant[1];
                if (wr_sel != WR_NONE) begin
                    state_nxt    = ST_WRITE;
                    cnt_nxt      = '0;
                    last_nxt     = 3'(byte_count(wr_sel) - 4'd1);
                    data_nxt     = d_sel;
                    ram_we_nxt   = 1'b1;
                    ram_addr_nxt = addr_sel;
                    ram_q_nxt    = d_sel[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last_idx <= '0;
            data     <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_q    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_idx <= last_nxt;
            data     <= data_nxt;
            ram_we   <= ram_we_nxt;
            ram_addr <= ram_addr_nxt;
            ram_q    <= ram_q_nxt;
            gnt0     <= gnt0_nxt;
            gnt1     <= gnt1_nxt;
        end
    end

endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: directed self-checking bench for store_sequencer.
// Expected RAM writes are queued as each store is driven and retired by a
// negedge monitor; grant order follows STORE_SEQ_RR_EN.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [1:0]  wr0, wr1;
    logic [15:0] addr0, addr1;
    logic [63:0] d0, d1;
    logic        gnt0, gnt1, ram_we, busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_q;

    int tests = 0;
    int fails = 0;
    logic [23:0] sb[$];     // {addr, byte}

    always #5 clk = ~clk;

    store_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .wr0      (wr0),
        .addr0    (addr0),
        .d0       (d0),
        .req1     (req1),
        .wr1      (wr1),
        .addr1    (addr1),
        .d1       (d1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] w);
        case (w)
            2'b01:   return 1;
            2'b10:   return 4;
            2'b11:   return 8;
            default: return 0;
        endcase
    endfunction

    task automatic push_bytes(input logic [15:0] a, input logic [63:0] d, input int n);
        logic [63:0] v;
        v = d;
        for (int k = 0; k < n; k++) begin
            sb.push_back({16'(a + 16'(k)), v[7:0]});
            v = v >> 8;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic r, input logic [1:0] w,
                         input logic [15:0] a, input logic [63:0] d);
        if (sel) begin
            req1 = r; wr1 = w; addr1 = a; d1 = d;
        end else begin
            req0 = r; wr0 = w; addr0 = a; d0 = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Full single store: capture, grant, byte count, held outputs afterwards.
    task automatic store_one(input bit sel, input logic [1:0] w,
                             input logic [15:0] a, input logic [63:0] d);
        int n, cyc;
        logic [63:0] lastb;
        n = nb(w);
        push_bytes(a, d, n);
        drive(sel, 1'b1, w, a, d);
        tick();
        check("gnt_sel", sel ? gnt1 : gnt0, 1);
        check("gnt_other", sel ? gnt0 : gnt1, 0);
        check("we_first", ram_we, (n != 0));
        // scrambled inputs after grant must not disturb the store
        drive(sel, 1'b0, 2'b11, 16'h0BAD, 64'hDEAD_BEEF_DEAD_BEEF);
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            cyc++;
            tick();
        end
        check("busy_cycles", cyc, n);
        check("we_after", ram_we, 0);
        if (n != 0) begin
            lastb = d >> (8 * (n - 1));
            check("q_hold", ram_q, lastb[7:0]);
            check("addr_hold", ram_addr, 16'(a + 16'(n - 1)));
        end
        tick();
        check("gnt_single", {gnt1, gnt0}, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed write %0h@%0h expected none", ram_q, ram_addr);
            end
            if (sb.size() != 0) begin
                logic [23:0] e;
                e = sb.pop_front();
                check("wr_addr", ram_addr, e[23:8]);
                check("wr_data", ram_q, e[7:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int order[4];
        int pc[2];
        logic [15:0] pa;
        logic [63:0] pd;

        rst_n = 1'b0;
        drive(0, 1'b0, 2'b00, '0, '0);
        drive(1, 1'b0, 2'b00, '0, '0);
        do_reset();
        check("rst_we", ram_we, 0);
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_q", ram_q, 0);

        // 8-byte store, then 4-byte store wrapping the address, then wr=00
        store_one(0, 2'b11, 16'h1000, 64'h8877_6655_4433_2211);
        store_one(0, 2'b10, 16'hFFFE, 64'h0000_0000_DDCC_BBAA);
        store_one(0, 2'b00, 16'h1234, 64'h0000_0000_0000_00FF);

        // simultaneous requests, two single-byte stores each
        do_reset();
`ifdef STORE_SEQ_RR_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 1, 1};
`endif
        pc = '{0, 0};
        drive(0, 1'b1, 2'b01, 16'h2000, 64'hA0);
        drive(1, 1'b1, 2'b01, 16'h3000, 64'hB0);
        for (int i = 0; i < 4; i++) begin
            int w;
            w = order[i];
            pa = (w == 1) ? 16'h3000 : 16'h2000;
            pd = (w == 1) ? 64'hB0 : 64'hA0;
            push_bytes(16'(pa + 16'(pc[w])), 64'(pd + 64'(pc[w])), 1);
            tick();
            check("arb_gnt0", gnt0, (w == 0));
            check("arb_gnt1", gnt1, (w == 1));
            check("arb_we", ram_we, 1);
            pc[w]++;
            if (pc[w] == 2) drive(w[0], 1'b0, 2'b00, '0, '0);
            else            drive(w[0], 1'b1, 2'b01, 16'(pa + 16'd1), 64'(pd + 64'd1));
        end
        tick();
        check("arb_idle_we", ram_we, 0);
        check("arb_drained", sb.size(), 0);

        // back-to-back stores from requester 1
        push_bytes(16'h4000, 64'h5A, 1);
        drive(1, 1'b1, 2'b01, 16'h4000, 64'h5A);
        tick();
        check("b2b_gnt_a", gnt1, 1);
        check("b2b_we_a", ram_we, 1);
        push_bytes(16'h4001, 64'hA5, 1);
        drive(1, 1'b1, 2'b01, 16'h4001, 64'hA5);
        tick();
        check("b2b_gnt_b", gnt1, 1);
        check("b2b_we_b", ram_we, 1);
        drive(1, 1'b0, 2'b00, '0, '0);
        tick();
        check("b2b_end_we", ram_we, 0);
        check("b2b_drained", sb.size(), 0);

        // reset during byte 3 of an 8-byte store
        push_bytes(16'h5000, 64'h0F0E_0D0C_0B0A_0908, 4);
        drive(0, 1'b1, 2'b11, 16'h5000, 64'h0F0E_0D0C_0B0A_0908);
        tick();
        check("abort_gnt", gnt0, 1);
        drive(0, 1'b0, 2'b00, '0, '0);
        tick();
        tick();
        tick();
        check("abort_byte3_addr", ram_addr, 16'h5003);
        rst_n = 1'b0;
        tick();
        check("abort_we", ram_we, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", ram_addr, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_replay", {busy, ram_we}, 0);
        end
        check("abort_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
